multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_WIDTH, default 6: width of the instruction opcode field.
REQ-002 Parameter STATE_WIDTH, default 4: width of the state register and STATE output.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: reset, asynchronous and active-high.
REQ-005 OPCODE  input  OPCODE_WIDTH: instruction register bits [31:26].
REQ-006 MEM_READY  input  1: memory access completes this cycle.
REQ-007 PC_WRITE, PC_WRITE_COND  output  1 each: unconditional and branch-conditional PC enables.
REQ-008 I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE  output  1 each: address-select mux, memory strobes, IR enable.
REQ-009 REG_DST, MEM_TO_REG, REG_WRITE  output  1 each: destination-register mux select, writeback mux select, register-file write.
REQ-010 ALU_SRC_A  output  1; ALU_SRC_B  output  2; ALU_OP  output  2; PC_SRC  output  2: ALU-operand, ALU-decoder and next-PC mux selects.
REQ-011 ILLEGAL_OP  output  1: one-cycle pulse on an unsupported opcode.
REQ-012 STATE  output  STATE_WIDTH: current state, for debug.

Function
REQ-013 The block SHALL be an FSM whose outputs decode from the state register, with MEM_READY gating as below.
REQ-014 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
REQ-015 FETCH: MEM_READ=1, I_OR_D=0, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=00, PC_SRC=00. IR_WRITE and PC_WRITE = MEM_READY. Go to DECODE when MEM_READY=1, otherwise hold.
REQ-016 DECODE: ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=00. Next state by OPCODE:
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x00 -> R_EXEC
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDI_EXEC
  - any other -> FETCH, with ILLEGAL_OP=1 for that cycle.
REQ-017 MEM_ADDR: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00. Go to MEM_RD if OPCODE=0x23, else MEM_WR.
REQ-018 MEM_RD: MEM_READ=1, I_OR_D=1. Hold until MEM_READY=1, then go to MEM_WB.
REQ-019 MEM_WB: REG_WRITE=1, MEM_TO_REG=1, REG_DST=0. Then FETCH.
REQ-020 MEM_WR: MEM_WRITE=1, I_OR_D=1. Hold until MEM_READY=1, then FETCH.
REQ-021 R_EXEC: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=10. Then R_WB.
REQ-022 R_WB: REG_WRITE=1, REG_DST=1, MEM_TO_REG=0. Then FETCH.
REQ-023 BRANCH: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=01, PC_WRITE_COND=1, PC_SRC=01. Then FETCH.
REQ-024 JUMP: PC_WRITE=1, PC_SRC=10. Then FETCH.
REQ-025 ADDI_EXEC: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00. Then ADDI_WB.
REQ-026 ADDI_WB: REG_WRITE=1, REG_DST=0, MEM_TO_REG=0. Then FETCH.
REQ-027 Any output not listed for a state SHALL be 0.
REQ-028 Instruction latency in cycles, with MEM_READY tied 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each extra MEM_READY=0 cycle in a memory state adds one cycle.
REQ-029 OPCODE SHALL be sampled only in DECODE and MEM_ADDR; changes in other states have no effect.
REQ-030 An unreachable state encoding SHALL return to FETCH on the next edge, with all strobes 0 while in it.

Reset
REQ-031 While RST=1, state SHALL be FETCH, and PC_WRITE, PC_WRITE_COND, IR_WRITE, REG_WRITE, MEM_WRITE, MEM_READ and ILLEGAL_OP SHALL be forced 0 asynchronously.
REQ-032 Reset asserted mid-instruction SHALL abandon it; no pending write completes.
REQ-033 The first FETCH cycle SHALL follow the first rising CLK edge after RST deasserts.

Structure
REQ-034 State encodings, opcode constants (0x00, 0x02, 0x04, 0x08, 0x23, 0x2B) and ALU_OP/PC_SRC/ALU_SRC_B codes SHALL live in a shared package, mips_ctrl_pkg.
REQ-035 The block SHALL be a single module: one sequential state register plus combinational next-state and output logic. No sub-module.

Verification
REQ-036 lw (0x23), MEM_READY=1: states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; REG_WRITE=1 with MEM_TO_REG=1 only in cycle 5.
REQ-037 R-type (0x00): REG_DST=1 and REG_WRITE=1 in cycle 4; ALU_OP=10 in cycle 3.
REQ-038 sw (0x2B) with MEM_READY low 3 cycles in MEM_WR: MEM_WRITE held 4 cycles, then FETCH.
REQ-039 beq (0x04) then j (0x02): PC_WRITE_COND=1 with PC_SRC=01 in cycle 3; then PC_WRITE=1 with PC_SRC=10 in cycle 3 of j.
REQ-040 Opcode 0x3F in DECODE: ILLEGAL_OP=1 for one cycle, next state FETCH, no REG_WRITE or MEM_WRITE asserted.
REQ-041 RST pulsed during MEM_RD, asynchronous to CLK: strobes drop immediately, STATE=FETCH, and the load's writeback never occurs.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes and mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SHL = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: one state register, combinational next-state and output decode.
// FETCH/DECODE | IF+ID; MEM_ADDR/MEM_RD/MEM_WB/MEM_WR | lw/sw; R_EXEC/R_WB | R-type;
// BRANCH | beq; JUMP | j; ADDI_EXEC/ADDI_WB | addi. Unused encodings fall back to FETCH.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [OPCODE_WIDTH-1:0] OPCODE,
    input  logic                    MEM_READY,
    output logic                    PC_WRITE,
    output logic                    PC_WRITE_COND,
    output logic                    I_OR_D,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic                    IR_WRITE,
    output logic                    REG_DST,
    output logic                    MEM_TO_REG,
    output logic                    REG_WRITE,
    output logic                    ALU_SRC_A,
    output logic [1:0]              ALU_SRC_B,
    output logic [1:0]              ALU_OP,
    output logic [1:0]              PC_SRC,
    output logic                    ILLEGAL_OP,
    output logic [STATE_WIDTH-1:0]  STATE
);

    state_e     state_q;
    state_e     state_d;
    ctrl_t      ctrl;
    logic [5:0] op;

    assign op = 6'(OPCODE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = MEM_READY;
                ctrl.pc_write  = MEM_READY;
                state_d        = MEM_READY ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SEXT_SHL;
                ctrl.alu_op    = ALUOP_ADD;
                if (is_mem_op(op)) begin
                    state_d = S_MEM_ADDR;
                end else if (op == OP_RTYPE) begin
                    state_d = S_R_EXEC;
                end else if (op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (op == OP_J) begin
                    state_d = S_JUMP;
                end else if (op == OP_ADDI) begin
                    state_d = S_ADDI_EXEC;
                end else begin
                    ctrl.illegal_op = 1'b1;
                    state_d         = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = MEM_READY ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                state_d        = MEM_READY ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
                state_d       = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are masked by RST directly so they drop the instant reset rises, not at the next edge.
    assign PC_WRITE      = ctrl.pc_write      & ~RST;
    assign PC_WRITE_COND = ctrl.pc_write_cond & ~RST;
    assign IR_WRITE      = ctrl.ir_write      & ~RST;
    assign REG_WRITE     = ctrl.reg_write     & ~RST;
    assign MEM_WRITE     = ctrl.mem_write     & ~RST;
    assign MEM_READ      = ctrl.mem_read      & ~RST;
    assign ILLEGAL_OP    = ctrl.illegal_op    & ~RST;

    assign I_OR_D     = ctrl.i_or_d;
    assign REG_DST    = ctrl.reg_dst;
    assign MEM_TO_REG = ctrl.mem_to_reg;
    assign ALU_SRC_A  = ctrl.alu_src_a;
    assign ALU_SRC_B  = ctrl.alu_src_b;
    assign ALU_OP     = ctrl.alu_op;
    assign PC_SRC     = ctrl.pc_src;
    assign STATE      = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction cycle tables with hand-derived controls.
module tb_multicycle_control;

    logic       CLK;
    logic       RST;
    logic [5:0] OPCODE;
    logic       MEM_READY;
    logic       PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE;
    logic       REG_DST, MEM_TO_REG, REG_WRITE, ALU_SRC_A, ILLEGAL_OP;
    logic [1:0] ALU_SRC_B, ALU_OP, PC_SRC;
    logic [3:0] STATE;
    logic [16:0] ctl;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .MEM_READY(MEM_READY),
        .PC_WRITE(PC_WRITE), .PC_WRITE_COND(PC_WRITE_COND), .I_OR_D(I_OR_D),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE),
        .REG_DST(REG_DST), .MEM_TO_REG(MEM_TO_REG), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
        .PC_SRC(PC_SRC), .ILLEGAL_OP(ILLEGAL_OP), .STATE(STATE)
    );

    // pcw pcwc iord mrd mwr irw rdst m2r rw asa asb[2] aop[2] psrc[2] ill
    assign ctl = {PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE,
                  REG_DST, MEM_TO_REG, REG_WRITE, ALU_SRC_A, ALU_SRC_B, ALU_OP, PC_SRC, ILLEGAL_OP};

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3;
    localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDI_EXEC = 4'd10, S_ADDI_WB = 4'd11;

    localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_RST        = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC        = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DEC_ILL    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_ADDR       = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MRD        = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWB        = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_MWR        = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_REX        = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB        = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BR         = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_J          = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_AWB        = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b1; MEM_READY = 1'b1; OPCODE = 6'h23;
        #2;
        total++;
        if (STATE !== S_FETCH || ctl !== C_RST) begin
            bad++;
            $display("FAIL reset_hold: state=%0d ctl=%b, want state=%0d ctl=%b", STATE, ctl, S_FETCH, C_RST);
        end
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (STATE !== S_FETCH || ctl !== C_RST) begin
            bad++;
            $display("FAIL reset_clocked: state=%0d ctl=%b, want state=%0d ctl=%b", STATE, ctl, S_FETCH, C_RST);
        end
        RST = 1'b0; MEM_READY = 1'b0;
        #1;
        total++;
        if (STATE !== S_FETCH || ctl !== C_FETCH_WAIT) begin
            bad++;
            $display("FAIL reset_release: state=%0d ctl=%b, want state=%0d ctl=%b", STATE, ctl, S_FETCH, C_FETCH_WAIT);
        end
        @(posedge CLK);
        #1;
        total++;
        if (STATE !== S_FETCH) begin
            bad++;
            $display("FAIL reset_fetch_hold: state=%0d, want state=%0d", STATE, S_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [27:0] tbl [6];
        logic mr; logic [5:0] op; logic [3:0] st; logic [16:0] c;
        tbl[0] = {1'b1, 6'h23, S_FETCH,    C_FETCH_RDY};
        tbl[1] = {1'b1, 6'h23, S_DECODE,   C_DEC};
        tbl[2] = {1'b1, 6'h23, S_MEM_ADDR, C_ADDR};
        tbl[3] = {1'b1, 6'h23, S_MEM_RD,   C_MRD};
        tbl[4] = {1'b1, 6'h23, S_MEM_WB,   C_MWB};
        tbl[5] = {1'b0, 6'h00, S_FETCH,    C_FETCH_WAIT};
        for (int i = 0; i < 6; i++) begin
            {mr, op, st, c} = tbl[i];
            MEM_READY = mr; OPCODE = op;
            #1;
            total++;
            if (STATE !== st || ctl !== c) begin
                bad++;
                $display("FAIL lw[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b", i, STATE, ctl, st, c);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_rtype();
        logic [27:0] tbl [5];
        logic mr; logic [5:0] op; logic [3:0] st; logic [16:0] c;
        tbl[0] = {1'b1, 6'h00, S_FETCH,  C_FETCH_RDY};
        tbl[1] = {1'b1, 6'h00, S_DECODE, C_DEC};
        tbl[2] = {1'b1, 6'h23, S_R_EXEC, C_REX};
        tbl[3] = {1'b1, 6'h2B, S_R_WB,   C_RWB};
        tbl[4] = {1'b0, 6'h00, S_FETCH,  C_FETCH_WAIT};
        for (int i = 0; i < 5; i++) begin
            {mr, op, st, c} = tbl[i];
            MEM_READY = mr; OPCODE = op;
            #1;
            total++;
            if (STATE !== st || ctl !== c) begin
                bad++;
                $display("FAIL rtype[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b", i, STATE, ctl, st, c);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_sw_wait();
        logic [27:0] tbl [9];
        logic mr; logic [5:0] op; logic [3:0] st; logic [16:0] c;
        tbl[0] = {1'b0, 6'h2B, S_FETCH,    C_FETCH_WAIT};
        tbl[1] = {1'b1, 6'h2B, S_FETCH,    C_FETCH_RDY};
        tbl[2] = {1'b1, 6'h2B, S_DECODE,   C_DEC};
        tbl[3] = {1'b1, 6'h2B, S_MEM_ADDR, C_ADDR};
        tbl[4] = {1'b0, 6'h2B, S_MEM_WR,   C_MWR};
        tbl[5] = {1'b0, 6'h00, S_MEM_WR,   C_MWR};
        tbl[6] = {1'b0, 6'h00, S_MEM_WR,   C_MWR};
        tbl[7] = {1'b1, 6'h00, S_MEM_WR,   C_MWR};
        tbl[8] = {1'b0, 6'h00, S_FETCH,    C_FETCH_WAIT};
        for (int i = 0; i < 9; i++) begin
            {mr, op, st, c} = tbl[i];
            MEM_READY = mr; OPCODE = op;
            #1;
            total++;
            if (STATE !== st || ctl !== c) begin
                bad++;
                $display("FAIL sw_wait[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b", i, STATE, ctl, st, c);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_back_to_back_beq_j();
        logic [27:0] tbl [7];
        logic mr; logic [5:0] op; logic [3:0] st; logic [16:0] c;
        tbl[0] = {1'b1, 6'h04, S_FETCH,  C_FETCH_RDY};
        tbl[1] = {1'b1, 6'h04, S_DECODE, C_DEC};
        tbl[2] = {1'b1, 6'h04, S_BRANCH, C_BR};
        tbl[3] = {1'b1, 6'h02, S_FETCH,  C_FETCH_RDY};
        tbl[4] = {1'b1, 6'h02, S_DECODE, C_DEC};
        tbl[5] = {1'b1, 6'h02, S_JUMP,   C_J};
        tbl[6] = {1'b0, 6'h00, S_FETCH,  C_FETCH_WAIT};
        for (int i = 0; i < 7; i++) begin
            {mr, op, st, c} = tbl[i];
            MEM_READY = mr; OPCODE = op;
            #1;
            total++;
            if (STATE !== st || ctl !== c) begin
                bad++;
                $display("FAIL beq_j[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b", i, STATE, ctl, st, c);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_addi();
        logic [27:0] tbl [5];
        logic mr; logic [5:0] op; logic [3:0] st; logic [16:0] c;
        tbl[0] = {1'b1, 6'h08, S_FETCH,     C_FETCH_RDY};
        tbl[1] = {1'b1, 6'h08, S_DECODE,    C_DEC};
        tbl[2] = {1'b1, 6'h08, S_ADDI_EXEC, C_ADDR};
        tbl[3] = {1'b1, 6'h08, S_ADDI_WB,   C_AWB};
        tbl[4] = {1'b0, 6'h08, S_FETCH,     C_FETCH_WAIT};
        for (int i = 0; i < 5; i++) begin
            {mr, op, st, c} = tbl[i];
            MEM_READY = mr; OPCODE = op;
            #1;
            total++;
            if (STATE !== st || ctl !== c) begin
                bad++;
                $display("FAIL addi[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b", i, STATE, ctl, st, c);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_illegal();
        logic [27:0] tbl [5];
        logic mr; logic [5:0] op; logic [3:0] st; logic [16:0] c;
        tbl[0] = {1'b1, 6'h3F, S_FETCH,  C_FETCH_RDY};
        tbl[1] = {1'b1, 6'h3F, S_DECODE, C_DEC_ILL};
        tbl[2] = {1'b1, 6'h01, S_FETCH,  C_FETCH_RDY};
        tbl[3] = {1'b1, 6'h01, S_DECODE, C_DEC_ILL};
        tbl[4] = {1'b0, 6'h01, S_FETCH,  C_FETCH_WAIT};
        for (int i = 0; i < 5; i++) begin
            {mr, op, st, c} = tbl[i];
            MEM_READY = mr; OPCODE = op;
            #1;
            total++;
            if (STATE !== st || ctl !== c) begin
                bad++;
                $display("FAIL illegal[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b", i, STATE, ctl, st, c);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset_mid_load();
        logic [27:0] tbl [4];
        logic mr; logic [5:0] op; logic [3:0] st; logic [16:0] c;
        tbl[0] = {1'b1, 6'h23, S_FETCH,    C_FETCH_RDY};
        tbl[1] = {1'b1, 6'h23, S_DECODE,   C_DEC};
        tbl[2] = {1'b1, 6'h23, S_MEM_ADDR, C_ADDR};
        tbl[3] = {1'b0, 6'h23, S_MEM_RD,   C_MRD};
        for (int i = 0; i < 4; i++) begin
            {mr, op, st, c} = tbl[i];
            MEM_READY = mr; OPCODE = op;
            #1;
            total++;
            if (STATE !== st || ctl !== c) begin
                bad++;
                $display("FAIL rst_mid[%0d]: state=%0d ctl=%b, want state=%0d ctl=%b", i, STATE, ctl, st, c);
            end
            @(posedge CLK);
            #1;
        end
        MEM_READY = 1'b1;
        #2;
        total++;
        if (STATE !== S_MEM_RD || MEM_READ !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: state=%0d mem_read=%b, want state=%0d mem_read=1", STATE, MEM_READ, S_MEM_RD);
        end
        RST = 1'b1;
        #1;
        total++;
        if (STATE !== S_FETCH || ctl !== C_RST) begin
            bad++;
            $display("FAIL rst_mid_async: state=%0d ctl=%b, want state=%0d ctl=%b", STATE, ctl, S_FETCH, C_RST);
        end
        @(posedge CLK);
        #1;
        total++;
        if (STATE !== S_FETCH || REG_WRITE !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_wb: state=%0d reg_write=%b, want state=%0d reg_write=0", STATE, REG_WRITE, S_FETCH);
        end
        RST = 1'b0; MEM_READY = 1'b0;
        #1;
        total++;
        if (STATE !== S_FETCH || ctl !== C_FETCH_WAIT) begin
            bad++;
            $display("FAIL rst_mid_release: state=%0d ctl=%b, want state=%0d ctl=%b", STATE, ctl, S_FETCH, C_FETCH_WAIT);
        end
        @(posedge CLK);
        #1;
        total++;
        if (STATE !== S_FETCH || REG_WRITE !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_after: state=%0d reg_write=%b, want state=%0d reg_write=0", STATE, REG_WRITE, S_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_wait();
        test_back_to_back_beq_j();
        test_addi();
        test_illegal();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
